m_ifetch: RTL

- Instruction-fetch stage that sits directly upstream of the 4K-word instruction memory (m_amemory).
- Owns the program counter and drives the memory word address.
- Captures the returned instruction word into an IF/ID pipeline register for the decode stage.
- Supports downstream stall, branch/jump redirect with flush, and a halt instruction that stops fetching.

---
 rtl/m_ifetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/m_ifetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, fills IF/ID.
// Optional fetch/stall performance counters are built when IFETCH_PERF_EN is defined.
module m_ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = 32'hffff_ffff,
    parameter logic [31:0] NOP_INSN  = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic [11:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    input  logic        w_stall,
    input  logic        w_redirect,
    input  logic [31:0] w_target,
    output logic        w_ifid_valid,
    output logic [31:0] w_ifid_pc,
    output logic [31:0] w_ifid_ir,
`ifdef IFETCH_PERF_EN
    output logic [31:0] w_fetch_cnt,
    output logic [31:0] w_stall_cnt,
`endif
    output logic        w_halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_ir_q, ifid_ir_d;
    logic        halted_q, halted_d;
    logic        capture_s;

    // Memory aliases every 16 KB: only the word bits of the PC reach the array.
    assign w_imem_addr  = pc_q[13:2];
    assign w_ifid_valid = ifid_valid_q;
    assign w_ifid_pc    = ifid_pc_q;
    assign w_ifid_ir    = ifid_ir_q;
    assign w_halted     = halted_q;

    // Next-state and IF/ID update; redirect overrides every other condition.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        halted_d     = halted_q;
        capture_s    = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!w_stall) begin
                    capture_s    = 1'b1;
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_ir_d    = w_imem_data;
                    if (w_imem_data == HALT_INSN) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                // The halt word stays visible until decode has taken it.
                if (!w_stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_ir_d    = NOP_INSN;
                end else begin
                    ifid_valid_d = ifid_valid_q;
                end
            end
            default: begin
                state_d      = S_BOOT;
                ifid_valid_d = 1'b0;
                ifid_ir_d    = NOP_INSN;
                halted_d     = 1'b0;
            end
        endcase

        if (w_redirect) begin
            capture_s    = 1'b0;
            state_d      = S_RUN;
            pc_d         = w_target & 32'hffff_fffc;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'h0000_0000;
            ifid_ir_d    = NOP_INSN;
            halted_d     = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Fetch state and IF/ID pipeline register.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_ir_q    <= NOP_INSN;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
            halted_q     <= halted_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_hit_s;

    assign w_fetch_cnt = fetch_cnt_q;
    assign w_stall_cnt = stall_cnt_q;

    // Counter increments: valid captures, and stalled cycles holding a real instruction.
    always_comb begin
        stall_hit_s = ((state_q == S_RUN) || (state_q == S_HALT)) && w_stall && ifid_valid_q;
        if (capture_s) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (stall_hit_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers, wrapping at 2^32.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
